// File: rtl/lut_bank_db.sv
// Double-buffered LUT bank: shadow tables are written in the background and swapped in by a
// commit pulse, while a two-stage valid/ready pipeline remaps NUM_LANES indices through the active bank.
module lut_bank_db #(
  parameter int NUM_LUTS       = 16,
  parameter int LUT_DEPTH      = 16,
  parameter int LUT_WIDTH      = 4,
  parameter int NUM_LANES      = 1024,
  parameter bit RESET_IDENTITY = 1'b0,
  localparam int IDX_W = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1,
  localparam int SEL_W = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_wr_valid,
  input  logic [SEL_W-1:0]               cfg_wr_lut,
  input  logic [IDX_W-1:0]               cfg_wr_addr,
  input  logic [LUT_WIDTH-1:0]           cfg_wr_data,
  input  logic                           cfg_commit,
  output logic                           active_bank,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_LANES*IDX_W-1:0]     in_idx,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_LANES*LUT_WIDTH-1:0] out_data
);
  localparam int MEM_LUTS      = 1 << SEL_W;
  localparam int MEM_DEPTH     = 1 << IDX_W;
  localparam int LANES_PER_LUT = NUM_LANES / NUM_LUTS;
  localparam logic [IDX_W:0] DEPTH_LIM = (IDX_W+1)'(LUT_DEPTH);
  localparam logic [SEL_W:0] LUTS_LIM  = (SEL_W+1)'(NUM_LUTS);

  // Arrays are padded to powers of two so every index is in bounds; padding is never written.
  logic [LUT_WIDTH-1:0] mem_q [2][MEM_LUTS][MEM_DEPTH];
  logic [LUT_WIDTH-1:0] mem_d [2][MEM_LUTS][MEM_DEPTH];

  logic                           active_bank_q, active_bank_d;
  logic                           s1_valid_q, s1_valid_d;
  logic                           s2_valid_q, s2_valid_d;
  logic [NUM_LANES*LUT_WIDTH-1:0] s1_data_q, s1_data_d;
  logic [NUM_LANES*LUT_WIDTH-1:0] s2_data_q, s2_data_d;
  logic [NUM_LANES*LUT_WIDTH-1:0] lookup;
  logic                           en;
  logic                           wr_ok;

  assign en    = !s2_valid_q || out_ready;
  assign wr_ok = cfg_wr_valid && ({1'b0, cfg_wr_lut} < LUTS_LIM) &&
                 ({1'b0, cfg_wr_addr} < DEPTH_LIM);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [IDX_W-1:0] lane_idx;
    assign lane_idx = in_idx[g*IDX_W +: IDX_W];
    assign lookup[g*LUT_WIDTH +: LUT_WIDTH] =
      ({1'b0, lane_idx} < DEPTH_LIM) ?
        mem_q[active_bank_q][SEL_W'(g / LANES_PER_LUT)][lane_idx] : '0;
  end

  always_comb begin
    active_bank_d = active_bank_q ^ cfg_commit;
    s1_valid_d    = s1_valid_q;
    s1_data_d     = s1_data_q;
    s2_valid_d    = s2_valid_q;
    s2_data_d     = s2_data_q;
    if (en) begin
      s1_valid_d = in_valid;
      if (in_valid) s1_data_d = lookup;
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_data_d = s1_data_q;
    end
    // The write goes to the shadow seen before the edge, so write+commit lands in the new active bank.
    mem_d = mem_q;
    if (wr_ok) mem_d[~active_bank_q][cfg_wr_lut][cfg_wr_addr] = cfg_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_bank_q <= 1'b0;
      s1_valid_q    <= 1'b0;
      s2_valid_q    <= 1'b0;
      s1_data_q     <= '0;
      s2_data_q     <= '0;
      for (int b = 0; b < 2; b++)
        for (int l = 0; l < MEM_LUTS; l++)
          for (int e = 0; e < MEM_DEPTH; e++)
            mem_q[b][l][e] <= RESET_IDENTITY ? LUT_WIDTH'(e) : '0;
    end else begin
      active_bank_q <= active_bank_d;
      s1_valid_q    <= s1_valid_d;
      s2_valid_q    <= s2_valid_d;
      s1_data_q     <= s1_data_d;
      s2_data_q     <= s2_data_d;
      mem_q         <= mem_d;
    end
  end

  assign active_bank = active_bank_q;
  assign in_ready    = en;
  assign out_valid   = s2_valid_q;
  assign out_data    = s2_data_q;

endmodule

// File: tb/tb_lut_bank_db.sv
// Directed bench for lut_bank_db with a table/queue reference model checked every cycle.
module tb_lut_bank_db;
  localparam int NL    = 16;
  localparam int LD    = 16;
  localparam int LW    = 4;
  localparam int LANES = 64;
  localparam int IW    = 4;
  localparam int SW    = 4;
  localparam int LPL   = LANES / NL;
  localparam int DW    = LANES * LW;
  localparam int XW    = LANES * IW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_wr_valid = 1'b0;
  logic [SW-1:0] cfg_wr_lut = '0;
  logic [IW-1:0] cfg_wr_addr = '0;
  logic [LW-1:0] cfg_wr_data = '0;
  logic          cfg_commit = 1'b0;
  logic          active_bank;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [XW-1:0] in_idx = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;

  lut_bank_db #(
    .NUM_LUTS(NL), .LUT_DEPTH(LD), .LUT_WIDTH(LW), .NUM_LANES(LANES), .RESET_IDENTITY(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr_valid(cfg_wr_valid), .cfg_wr_lut(cfg_wr_lut), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data), .cfg_commit(cfg_commit), .active_bank(active_bank),
    .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            edge_n;
  } beat_t;

  beat_t         sbq[$];
  logic [LW-1:0] m_mem [2][NL][LD];
  int            m_bank;
  int            edge_cnt = 0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int b = 0; b < 2; b++)
      for (int l = 0; l < NL; l++)
        for (int e = 0; e < LD; e++)
          m_mem[b][l][e] = LW'(e);
    m_bank = 0;
    sbq.delete();
  endtask

  function automatic logic [DW-1:0] m_lookup(input logic [XW-1:0] idx, input int bank);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      r[i*LW +: LW] = m_mem[bank][i/LPL][idx[i*IW +: IW]];
    return r;
  endfunction

  function automatic logic [XW-1:0] all_idx(input logic [IW-1:0] v);
    logic [XW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*IW +: IW] = v;
    return r;
  endfunction

  // Reference: lookups happen at acceptance in the bank active before the edge, then writes, then commit.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reset();
    end else begin
      beat_t nb;
      edge_cnt++;
      if (out_valid && out_ready && sbq.size() > 0) void'(sbq.pop_front());
      if (in_valid && in_ready) begin
        nb.data   = m_lookup(in_idx, m_bank);
        nb.edge_n = edge_cnt;
        sbq.push_back(nb);
      end
      if (cfg_wr_valid) m_mem[m_bank ^ 1][cfg_wr_lut][cfg_wr_addr] = cfg_wr_data;
      if (cfg_commit) m_bank = m_bank ^ 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready_rule", DW'(in_ready), DW'(!out_valid || out_ready));
      chk("active_bank", DW'(active_bank), DW'(m_bank[0]));
      if (out_valid) begin
        chk("out_has_pending_beat", DW'(sbq.size() != 0), DW'(1));
        if (sbq.size() != 0) begin
          chk("out_data", out_data, sbq[0].data);
          chk("out_not_early", DW'(sbq[0].edge_n < edge_cnt), DW'(1));
        end
      end else if (sbq.size() != 0) begin
        chk("out_not_late", DW'(sbq[0].edge_n == edge_cnt), DW'(1));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int lut, input int addr, input int data, input bit commit);
    cfg_wr_valid = 1'b1;
    cfg_wr_lut   = SW'(lut);
    cfg_wr_addr  = IW'(addr);
    cfg_wr_data  = LW'(data);
    cfg_commit   = commit;
    step();
    cfg_wr_valid = 1'b0;
    cfg_commit   = 1'b0;
  endtask

  task automatic lookup1(input logic [IW-1:0] v, output logic [DW-1:0] res);
    in_idx   = all_idx(v);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    res = out_data;
  endtask

  logic [DW-1:0] exp_id;
  logic [DW-1:0] r;
  logic [LW-1:0] seqv [6];
  int            got;
  int            cyc;
  int            k;
  bit            acc;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_out_data", out_data, DW'(0));
    chk("rst_in_ready", DW'(in_ready), DW'(1));
    chk("rst_bank", DW'(active_bank), DW'(0));
    #9 rst_n = 1'b1;
    step();

    // Identity reset: lane i holds i mod 16, visible two cycles after in_valid.
    out_ready = 1'b1;
    exp_id = '0;
    for (int i = 0; i < LANES; i++) begin
      in_idx[i*IW +: IW] = IW'(i % 16);
      exp_id[i*LW +: LW] = LW'(i % 16);
    end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("id_not_early", DW'(out_valid), DW'(0));
    step();
    chk("id_valid", DW'(out_valid), DW'(1));
    chk("id_data", out_data, exp_id);

    // Shadow isolation, then commit.
    wr(0, 3, 'hA, 1'b0);
    lookup1(4'd3, r);
    chk("shadow_iso", DW'(r[3:0]), DW'(3));
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    chk("commit_bank", DW'(active_bank), DW'(1));
    lookup1(4'd3, r);
    chk("commit_lane0", DW'(r[3:0]), DW'('hA));
    chk("commit_lane4", DW'(r[19:16]), DW'(3));

    // Commit boundary: commit on beat 2's acceptance edge.
    for (int l = 0; l < NL; l++) wr(l, 5, 7, 1'b0);
    got = 0;
    for (int b = 0; b < 6; b++) begin
      in_valid   = (b < 4);
      in_idx     = all_idx(4'd5);
      cfg_commit = (b == 2);
      step();
      if (out_valid && got < 4) begin
        seqv[got] = out_data[3:0];
        got++;
      end
    end
    in_valid   = 1'b0;
    cfg_commit = 1'b0;
    chk("cb_count", DW'(got), DW'(4));
    chk("cb_beat0", DW'(seqv[0]), DW'(5));
    chk("cb_beat1", DW'(seqv[1]), DW'(5));
    chk("cb_beat2", DW'(seqv[2]), DW'(5));
    chk("cb_beat3", DW'(seqv[3]), DW'(7));
    chk("cb_bank", DW'(active_bank), DW'(0));

    // Backpressure: out_ready low for 3 cycles mid-stream; lane 0 carries a sequence number.
    got = 0;
    cyc = 0;
    k = 0;
    while (got < 6 && cyc < 40) begin
      in_valid = (k < 6);
      in_idx   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      in_idx[IW-1:0] = IW'(8 + k);
      out_ready = !(cyc >= 3 && cyc < 6);
      @(negedge clk);
      if (out_valid && !out_ready) chk("bp_in_ready_low", DW'(in_ready), DW'(0));
      if (out_valid && out_ready) begin
        seqv[got] = out_data[3:0];
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) k++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", DW'(got), DW'(6));
    for (int i = 0; i < 6; i++) chk("bp_seq", DW'(seqv[i]), DW'(8 + i));

    // Write and commit in the same cycle.
    wr(0, 2, 'hC, 1'b1);
    chk("wc_bank", DW'(active_bank), DW'(1));
    lookup1(4'd2, r);
    chk("wc_lane0", DW'(r[3:0]), DW'('hC));
    chk("wc_lane4", DW'(r[19:16]), DW'(2));

    // Asynchronous reset with two beats in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_idx    = all_idx(4'd1);
    step();
    in_idx    = all_idx(4'd4);
    step();
    in_valid  = 1'b0;
    chk("ar_pre_valid", DW'(out_valid), DW'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", DW'(out_valid), DW'(0));
    chk("ar_bank", DW'(active_bank), DW'(0));
    chk("ar_out_data", out_data, DW'(0));
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    lookup1(4'd3, r);
    chk("ar_restored_b0", DW'(r[3:0]), DW'(3));
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    lookup1(4'd2, r);
    chk("ar_restored_b1", DW'(r[3:0]), DW'(2));

    step();
    step();
    step();
    chk("queue_drained", DW'(sbq.size()), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
